// File: rtl/fb_arbiter_if.sv
// rtl/fb_arbiter_if.sv - video/host request, read return and BRAM command signal bundle
interface fb_arbiter_if #(
  parameter int Dwidth = 12,
  parameter int Awidth = 15
);
  logic              vid_req;
  logic [Awidth-1:0] vid_addr;
  logic              vid_gnt;
  logic              vid_rvalid;
  logic [Dwidth-1:0] vid_rdata;

  logic              host_req;
  logic              host_we;
  logic [Awidth-1:0] host_addr;
  logic [Dwidth-1:0] host_wdata;
  logic              host_gnt;
  logic              host_rvalid;
  logic [Dwidth-1:0] host_rdata;

  logic              bram_we;
  logic [Awidth-1:0] bram_addr;
  logic [Dwidth-1:0] bram_din;
  logic [Dwidth-1:0] bram_dout;

  modport slave (
    input  vid_req, vid_addr, host_req, host_we, host_addr, host_wdata, bram_dout,
    output vid_gnt, vid_rvalid, vid_rdata, host_gnt, host_rvalid, host_rdata,
    output bram_we, bram_addr, bram_din
  );

  modport master (
    output vid_req, vid_addr, host_req, host_we, host_addr, host_wdata, bram_dout,
    input  vid_gnt, vid_rvalid, vid_rdata, host_gnt, host_rvalid, host_rdata,
    input  bram_we, bram_addr, bram_din
  );
endinterface

// File: rtl/fb_arbiter.sv
// rtl/fb_arbiter.sv - single-port framebuffer BRAM arbiter, video priority with host starvation guard
module fb_arbiter #(
  parameter int Dword      = 16384,
  parameter int Dwidth     = 12,
  parameter int Awidth     = $clog2(Dword + 1),
  parameter int STARVE_MAX = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  fb_arbiter_if.slave   bus
);
  localparam int                Swidth     = $clog2(STARVE_MAX + 1);
  localparam logic [Swidth-1:0] STARVE_SAT = Swidth'(STARVE_MAX);
  localparam logic [Awidth:0]   DEPTH      = (Awidth + 1)'(Dword);

  typedef enum logic {
    OWN_VID  = 1'b0,
    OWN_HOST = 1'b1
  } owner_e;

  logic [Swidth-1:0] starve_cnt_q, starve_cnt_d;
  logic              tag_read_q, tag_read_d;
  owner_e            tag_owner_q, tag_owner_d;
  logic              tag_oob_q, tag_oob_d;

  logic              vid_oob, host_oob;
  logic              host_win;
  logic              vid_gnt, host_gnt;
  logic [Dwidth-1:0] ret_data;

  // Grants are forced low while in reset so nothing reaches the BRAM.
  always_comb begin
    vid_oob  = {1'b0, bus.vid_addr} >= DEPTH;
    host_oob = {1'b0, bus.host_addr} >= DEPTH;
    host_win = bus.host_req && (!bus.vid_req || (starve_cnt_q == STARVE_SAT));
    host_gnt = rst_n && host_win;
    vid_gnt  = rst_n && bus.vid_req && !host_win;
  end

  always_comb begin
    bus.bram_we   = 1'b0;
    bus.bram_addr = '0;
    bus.bram_din  = '0;
    if (vid_gnt) begin
      bus.bram_addr = bus.vid_addr;
    end else if (host_gnt) begin
      bus.bram_addr = bus.host_addr;
      bus.bram_din  = bus.host_wdata;
      bus.bram_we   = bus.host_we && !host_oob;
    end
  end

  always_comb begin
    starve_cnt_d = '0;
    if (bus.host_req && !host_gnt) begin
      starve_cnt_d = (starve_cnt_q == STARVE_SAT) ? STARVE_SAT : starve_cnt_q + Swidth'(1);
    end
  end

  // Tag describes the access whose BRAM data appears next cycle.
  always_comb begin
    tag_read_d  = 1'b0;
    tag_owner_d = OWN_VID;
    tag_oob_d   = 1'b0;
    if (vid_gnt) begin
      tag_read_d = 1'b1;
      tag_oob_d  = vid_oob;
    end else if (host_gnt && !bus.host_we) begin
      tag_read_d  = 1'b1;
      tag_owner_d = OWN_HOST;
      tag_oob_d   = host_oob;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
      tag_read_q   <= 1'b0;
      tag_owner_q  <= OWN_VID;
      tag_oob_q    <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      tag_read_q   <= tag_read_d;
      tag_owner_q  <= tag_owner_d;
      tag_oob_q    <= tag_oob_d;
    end
  end

  always_comb begin
    ret_data        = tag_oob_q ? '0 : bus.bram_dout;
    bus.vid_gnt     = vid_gnt;
    bus.host_gnt    = host_gnt;
    bus.vid_rvalid  = tag_read_q && (tag_owner_q == OWN_VID);
    bus.host_rvalid = tag_read_q && (tag_owner_q == OWN_HOST);
    bus.vid_rdata   = bus.vid_rvalid ? ret_data : '0;
    bus.host_rdata  = bus.host_rvalid ? ret_data : '0;
  end
endmodule

// File: tb/tb_fb_arbiter.sv
// tb/tb_fb_arbiter.sv - scoreboard bench for fb_arbiter with behavioural BRAM
module tb_fb_arbiter;
  localparam int DWORD = 16384;
  localparam int DW    = 12;
  localparam int AW    = 15;
  localparam int SMAX  = 7;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fb_arbiter_if #(.Dwidth(DW), .Awidth(AW)) bus ();

  fb_arbiter #(.Dword(DWORD), .Dwidth(DW), .Awidth(AW), .STARVE_MAX(SMAX)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [DW-1:0] bram_mem [DWORD] = '{default: '0};
  always @(posedge clk) begin
    if (bus.bram_we && int'(bus.bram_addr) < DWORD) bram_mem[bus.bram_addr] <= bus.bram_din;
    bus.bram_dout <= (int'(bus.bram_addr) < DWORD) ? bram_mem[bus.bram_addr] : '0;
  end

  typedef struct {
    int            cyc;
    logic          host;
    logic [DW-1:0] data;
  } ret_t;

  ret_t          sb[$];
  logic [DW-1:0] shadow [int];
  int            m_starve = 0;
  int            cyc      = 0;
  int            checks   = 0;
  int            errors   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_rd(input int a);
    if (a >= DWORD) return '0;
    if (shadow.exists(a)) return shadow[a];
    return '0;
  endfunction

  task automatic step(input logic vr, input int va, input logic hr, input logic hw,
                      input int ha, input int hd);
    logic hwin;
    ret_t r;
    @(negedge clk);
    bus.vid_req    = vr;
    bus.vid_addr   = AW'(va);
    bus.host_req   = hr;
    bus.host_we    = hw;
    bus.host_addr  = AW'(ha);
    bus.host_wdata = DW'(hd);
    #1;
    cyc++;
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      r = sb.pop_front();
      check_eq("vid_rvalid", bus.vid_rvalid, !r.host);
      check_eq("host_rvalid", bus.host_rvalid, r.host);
      check_eq("vid_rdata", bus.vid_rdata, r.host ? '0 : r.data);
      check_eq("host_rdata", bus.host_rdata, r.host ? r.data : '0);
    end else begin
      check_eq("no_rvalid", {bus.vid_rvalid, bus.host_rvalid}, 0);
    end
    check_eq("starve_cnt", dut.starve_cnt_q, m_starve);
    hwin = hr && (!vr || m_starve == SMAX);
    check_eq("host_gnt", bus.host_gnt, hwin);
    check_eq("vid_gnt", bus.vid_gnt, vr && !hwin);
    if (hwin) begin
      check_eq("bram_addr_h", bus.bram_addr, ha);
      check_eq("bram_we_h", bus.bram_we, hw && ha < DWORD);
      check_eq("bram_din_h", bus.bram_din, hd);
      if (hw) begin
        if (ha < DWORD) shadow[ha] = DW'(hd);
      end else begin
        sb.push_back('{cyc + 1, 1'b1, model_rd(ha)});
      end
    end else if (vr) begin
      check_eq("bram_addr_v", bus.bram_addr, va);
      check_eq("bram_we_v", bus.bram_we, 0);
      sb.push_back('{cyc + 1, 1'b0, model_rd(va)});
    end else begin
      check_eq("bram_idle", {bus.bram_we, bus.bram_addr, bus.bram_din}, 0);
    end
    if (hr && !hwin) m_starve = (m_starve == SMAX) ? SMAX : m_starve + 1;
    else m_starve = 0;
  endtask

  initial begin
    int exp_seq[4] = '{1, 2, 3, 0};
    int ra, rd;

    bus.vid_req = 1'b1; bus.vid_addr = '0;
    bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 'h10; bus.host_wdata = 'h111;
    #12;
    check_eq("rst_gnts", {bus.vid_gnt, bus.host_gnt}, 0);
    check_eq("rst_we", bus.bram_we, 0);
    check_eq("rst_rvalid", {bus.vid_rvalid, bus.host_rvalid}, 0);
    check_eq("rst_rdata", {bus.vid_rdata, bus.host_rdata}, 0);
    check_eq("rst_starve", dut.starve_cnt_q, 0);
    bus.vid_req = 1'b0; bus.host_req = 1'b0; bus.host_we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // host write then read-back
    step(0, 0, 1, 1, 'h10, 'hABC);
    check_eq("wr_bram_we", bus.bram_we, 1);
    step(0, 0, 1, 0, 'h10, 0);
    step(0, 0, 0, 0, 0, 0);
    check_eq("rd_host_rdata", bus.host_rdata, 'hABC);

    // continuous contention: host wins every 8th cycle
    for (int i = 0; i < 20; i++) begin
      step(1, 'h20, 1, 0, 'h30, 0);
      check_eq("starve_pattern", bus.host_gnt, (i % 8) == 7);
      check_eq("both_gnt", bus.vid_gnt && bus.host_gnt, 0);
    end
    step(0, 0, 0, 0, 0, 0);

    // alternating owners without bubbles
    step(0, 0, 1, 1, 'h100, 'h123);
    step(0, 0, 1, 1, 'h200, 'h456);
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) step(1, 'h100, 0, 0, 0, 0);
      else step(0, 0, 1, 0, 'h200, 0);
    end

    // out-of-range write dropped, read returns zero
    step(0, 0, 1, 1, 'h4000, 'h555);
    check_eq("oob_we", bus.bram_we, 0);
    step(0, 0, 1, 0, 'h4000, 0);
    step(0, 0, 0, 0, 0, 0);
    check_eq("oob_rvalid", bus.host_rvalid, 1);
    check_eq("oob_rdata", bus.host_rdata, 0);

    // starvation counter climbs then clears on drop
    for (int k = 0; k < 4; k++) begin
      step(1, 'h40, k < 3, 0, 'h41, 0);
      @(posedge clk); #1;
      check_eq("starve_seq", dut.starve_cnt_q, exp_seq[k]);
    end

    // random traffic including read-after-write and oob
    for (int i = 0; i < 60; i++) begin
      ra = ($urandom_range(0, 9) == 0) ? 'h4000 + $urandom_range(0, 3) : $urandom_range(0, 15);
      rd = $urandom_range(0, 4095);
      step($urandom_range(0, 2) != 0, $urandom_range(0, 15), $urandom_range(0, 1),
           $urandom_range(0, 1), ra, rd);
    end
    step(0, 0, 1, 1, 'h50, 'h7E7);
    step(0, 0, 1, 0, 'h50, 0);
    step(0, 0, 0, 0, 0, 0);

    // reset strikes while a video return is in flight
    step(1, 'h100, 0, 0, 0, 0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    sb.delete();
    m_starve = 0;
    #1;
    check_eq("mid_rst_vrvalid", bus.vid_rvalid, 0);
    check_eq("mid_rst_vgnt", bus.vid_gnt, 0);
    check_eq("mid_rst_vrdata", bus.vid_rdata, 0);
    bus.host_req = 1'b1; bus.host_we = 1'b1;
    #1;
    check_eq("mid_rst_hgnt", bus.host_gnt, 0);
    check_eq("mid_rst_we", bus.bram_we, 0);
    bus.vid_req = 1'b0; bus.host_req = 1'b0; bus.host_we = 1'b0;
    @(negedge clk); #2;
    rst_n = 1'b1;
    step(1, 'h60, 1, 0, 'h61, 0);
    check_eq("post_rst_vgnt", bus.vid_gnt, 1);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check_eq("sb_drain", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
